// File: rtl/fifo_upsize_fwft.sv
// Width upsizer: drains an FWFT FIFO read port and packs RATIO narrow words
// into one wide word with a contiguous keep mask; packets flush on in_last.

module fifo_upsize_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hit,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         kq,
  output logic [W-1:0] merged
);
  assign merged = hit ? din : q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      kq <= 1'b0;
    end else if (clear) begin
      q  <= '0;
      kq <= 1'b0;
    end else if (load && hit) begin
      q  <= din;
      kq <= 1'b1;
    end
  end
endmodule

module fifo_upsize_fwft #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_last,
  input  logic                      in_empty,
  output logic                      in_rd_en,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]          out_keep,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [RATIO-1:0][IN_WIDTH-1:0] asm_data, merged;
  logic [RATIO-1:0]               asm_keep, lane_hit;
  logic [IDX_W-1:0]               idx;
  logic                           out_free, complete, acc_fill, acc_done;

  assign out_free = !out_valid || out_ready;
  assign complete = (idx == IDX_W'(RATIO-1)) || in_last;
  assign in_rd_en = !in_empty && (!complete || out_free);
  assign acc_fill = in_rd_en && !complete;
  assign acc_done = in_rd_en && complete;

  // Lanes above idx are always zero, so the merged word is already masked.
  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    assign lane_hit[l] = (idx == IDX_W'(l));
    fifo_upsize_lane #(.W(IN_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .hit    (lane_hit[l]),
      .load   (acc_fill),
      .clear  (acc_done),
      .din    (in_data),
      .q      (asm_data[l]),
      .kq     (asm_keep[l]),
      .merged (merged[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (acc_done) begin
      idx       <= '0;
      out_data  <= merged;
      out_keep  <= asm_keep | lane_hit;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (acc_fill) idx <= idx + IDX_W'(1);
    end
  end
endmodule

// File: doc/fifo_upsize_fwft.md
# fifo_upsize_fwft

Width upsizer that drains a first-word-fall-through FIFO read port and packs RATIO narrow words into one wide word with a per-lane keep mask.
It sits directly downstream of the synchronous FWFT FIFO: it consumes `dout`/`empty` and drives `rd_en`, and presents a registered valid/ready stream to the wide consumer, e.g. a NoC link or DMA engine.
Packets end on `in_last`; a partially filled wide word is flushed with its unused lanes masked off.

## Interface
- `IN_WIDTH`, default 8: width of one narrow FIFO word.
- `RATIO`, default 4: narrow words per wide word; must be ≥1. Output width is IN_WIDTH*RATIO.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  IN_WIDTH  FIFO `dout`; valid whenever `in_empty`=0.
- `in_last`  in  1  end-of-packet flag, travelling alongside `in_data` (carried as an extra FIFO bit).
- `in_empty`  in  1  FIFO `empty`.
- `in_rd_en`  out  1  FIFO `rd_en`; pops the current head word.
- `out_data`  out  IN_WIDTH*RATIO  packed wide word; lane 0 occupies the LSBs.
- `out_keep`  out  RATIO  bit i = lane i holds valid data; always a contiguous run starting at bit 0.
- `out_last`  out  1  wide word ends a packet.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word this cycle.

## Operation
- **Assembly buffer.** Holds `asm_data`, `asm_keep` and lane index `idx` (0..RATIO-1, width $clog2(RATIO) with a minimum of 1 bit).
- **Output register.** Holds `out_data`, `out_keep`, `out_last` and `out_valid`.
- **Derived signals:**
  - `out_free` = !out_valid || out_ready.
  - `complete` = (idx == RATIO-1) || in_last.
  - `in_rd_en` = !in_empty && (!complete || out_free).
- **Accept, not completing** (in_rd_en=1, complete=0):
  - write `in_data` into lane `idx`;
  - set `asm_keep[idx]`;
  - idx++.
- **Accept, completing** (in_rd_en=1, complete=1):
  - load the output register with the assembly buffer merged with the current word at lane `idx`;
  - `out_keep` = asm_keep | (1<<idx);
  - `out_last` = in_last;
  - `out_valid` = 1;
  - clear the assembly buffer: asm_data=0, asm_keep=0, idx=0.
- **Unused lanes.** Lanes of a partial word are driven to 0 in `out_data`.
- **Output draining.** If out_valid && out_ready and no completing accept happens this cycle, `out_valid` goes to 0. The other output register fields hold their last value.
- **Word reaching RATIO without in_last.** Emitted with out_last=0 and keep all-ones. The next word starts at lane 0.
- **Stall behaviour.** While the output is stalled (out_valid=1, out_ready=0), non-completing words keep being accepted. Up to RATIO-1 words can be buffered before `in_rd_en` drops.
- **RATIO=1.** Every accepted word completes: keep=1 and out_last=in_last. The block degenerates to a one-stage registered FWFT-to-valid/ready adapter.
- **Reset.** Asserting rst_n mid-packet discards the partial assembly buffer and any pending output word. No recovery is attempted.

## Timing
- **Reset values:**
  - out_valid=0, out_data=0, out_keep=0, out_last=0;
  - idx=0, asm_data=0, asm_keep=0;
  - in_rd_en=0, because `in_rd_en` is combinational and `in_empty` is 1 out of the FIFO's reset.
- **Combinational paths.** `in_rd_en` depends combinationally on in_empty, in_last, idx, out_valid and out_ready. There is no path from out_ready to out_valid or out_data.
- **Latency.** The completing word is popped in cycle t; out_valid=1 in cycle t+1.
- **Throughput.** One narrow word per cycle sustained while out_ready=1. Back-to-back wide words appear on consecutive cycles every RATIO input cycles.
- **Simultaneous drain and load.** out_ready=1 with a completing accept in the same cycle replaces the output word with no bubble.
- **FIFO contract.** `in_rd_en` is never asserted while in_empty=1.

## Test plan
- **Full-width packing.** IN_WIDTH=8, RATIO=4; push 0x11,0x22,0x33,0x44 (last on 0x44), out_ready=1 → one beat: out_data=0x44332211, keep=4'b1111, last=1, one cycle after 0x44 is popped.
- **Partial flush.** Push 0xA1,0xA2 (last on 0xA2) → out_data=0x0000A2A1, keep=4'b0011, last=1. A following 0xB1 (last) yields 0x000000B1, keep=4'b0001.
- **Long packet, no gaps.** 8-word packet 0x01..0x08, last on 0x08, FIFO never empty → beats 0x04030201 (last=0) then 0x08070605 (last=1) exactly 4 cycles apart; in_rd_en high for 8 consecutive cycles.
- **Back-pressure.** Hold out_ready=0 with one wide word pending. Push 4 more words: the first 3 are accepted, then in_rd_en=0 with 0x..04 at the FIFO head. Release out_ready → the pending word drains and the new word loads in the same cycle, no bubble.
- **Reset mid-packet.** Pop 2 words, assert rst_n=0 asynchronously mid-cycle → out_valid=0 and keep=0 immediately. After release, a new packet 0xC1 (last) emits 0x000000C1 with keep=4'b0001 and no stale lanes.
- **Random soak.** RATIO=1 and RATIO=3; random in_empty and out_ready stalls against a scoreboard model → every input byte is delivered in order, keep is contiguous, and in_rd_en is never asserted while in_empty=1.
